rgmii_xmit: RTL and testbench
=============================

# rgmii_xmit

RGMII transmit PHY-side interface and frame serializer, the transmit counterpart of the RGMII receive path. It accepts a byte stream through a valid/ready/last handshake and frames it with preamble and SFD. It enforces the inter-frame gap and drives the 4-bit DDR RGMII pins (TXC, TXD, TX_CTL) through `oddr` primitives. It sits between the MAC/packet builder and the board pins in the 1000 Mb/s path.

## Interface
- `IFG_BYTES`, 12: idle byte-times inserted after each frame (min 1).
- `PREAMBLE_BYTES`, 7: count of 0x55 bytes before the SFD (min 1).
- `clk` input 1: 125 MHz transmit clock; all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `s_data` input 8: payload byte.
- `s_valid` input 1: `s_data` valid.
- `s_last` input 1: current byte is the frame's final payload byte.
- `s_ready` output 1: block accepts the byte this cycle.
- `busy` output 1: high in any state other than IDLE.
- `underrun` output 1: one-cycle pulse when `s_valid` drops mid-frame.
- `mii_txc` output 1: forwarded clock, `oddr` with d1=1, d2=0.
- `mii_txd` output 4: DDR data; rising edge carries bits [3:0], falling edge carries bits [7:4].
- `mii_txctl` output 1: DDR control; rising edge carries `tx_en`, falling edge carries `tx_en ^ tx_er`.

## Operation
- Internal GMII stage: registered `tx_en`, `tx_er`, `txd[7:0]`, all reset to 0. The `oddr` stage drives the pins from these registers.
- FSM states: IDLE → PREAMBLE → SFD → DATA → [PAD → FCS] → IFG → IDLE.
- IDLE: `tx_en`=0, `txd`=0x00. When `s_valid`=1, go to PREAMBLE. The byte is not consumed in IDLE.
- PREAMBLE: `txd`=0x55 for `PREAMBLE_BYTES` cycles, `tx_en`=1.
- SFD: `txd`=0xD5 for one cycle.
- DATA: `s_ready`=1 and `s_ready` is combinational with respect to state only, never with respect to `s_valid`.
  - Each cycle with `s_valid`=1: `txd`=`s_data`.
  - When `s_last`=1, exit DATA. With the FCS macro, go to PAD if fewer than 60 bytes were sent, otherwise go to FCS. Without the macro, go to IFG.
- Underrun: in DATA with `s_valid`=0:
  - Drive one byte with `tx_en`=1, `tx_er`=1, `txd`=0x00, and pulse `underrun`.
  - Enter DRAIN. DRAIN holds `s_ready`=1 and discards bytes until `s_valid` and `s_last` are both 1, with `tx_en`=0. Then go to IFG.
  - No PAD or FCS is sent for an aborted frame.
- PAD: `txd`=0x00 until the byte counter reaches 60.
- Byte counter: 6 bits, saturating at 60. It counts DATA and PAD bytes only.
- FCS (macro only): 4 bytes of `~crc`, LSB byte first.
  - CRC is CRC-32, reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF in SFD.
  - CRC is updated with every DATA and PAD byte.
- IFG: `tx_en`=0 for `IFG_BYTES` cycles, `s_ready`=0. Then go to IDLE.
- Reset mid-frame: all state clears immediately. Pins show `tx_en`=0 after the `oddr` latency, and the partial frame is truncated with no error byte.
- `tx_er` is 0 everywhere except the underrun byte.

## Timing
- Reset values: `s_ready`=0, `busy`=0, `underrun`=0, GMII registers 0, `mii_txctl` low on both edges, `mii_txd`=0.
- `s_valid` sampled in IDLE → first 0x55 in the GMII register on the next posedge → first 0x55 on the pins one further `clk` later (`oddr` latency).
- A payload byte accepted at edge N appears in the GMII register after edge N and on the pins one cycle later. Latency is fixed with no bubbles.
- A back-to-back frame starts no earlier than `IFG_BYTES` idle cycles after the last FCS byte (last data byte when the macro is off).
- `s_valid` held high through IFG is not consumed early.

## Configuration
- `RGMII_XMIT_FCS_EN` defined: minimum-length padding to 60 bytes plus 4-byte CRC-32 FCS are appended, for a 64-byte minimum frame.
- Macro not defined: PAD and FCS states and the CRC logic are omitted. Payload passes verbatim; upstream supplies padding and FCS.

## Test plan
- 64-byte payload 0x00..0x3F, macro off → pins decode to 7×0x55, 0xD5, 0x00..0x3F, then `tx_en`=0 for exactly 12 byte-times; 72 `tx_en` cycles total.
- 1-byte payload 0xAB, macro on → 0xAB + 59×0x00 + 4 FCS bytes. A CRC run over all post-SFD bytes, including the FCS, leaves residue register 0xDEBB20E3.
- Two frames presented back to back → gap between final byte of frame 1 and first 0x55 of frame 2 is exactly 12 cycles; `s_ready` is 0 throughout that gap.
- `s_valid` dropped after 10 payload bytes → one byte with `tx_en`=1, `tx_er`=1, so `mii_txctl` is high on rise and low on fall. `underrun` pulses once. Remaining input is discarded through `s_last` and no FCS is emitted.
- `rst` asserted during the 5th payload byte → pins show `tx_en`=0 within 2 cycles and `busy`=0. The next frame starts cleanly with a full preamble.
- `mii_txc` check → toggles each half-period, aligned with `mii_txd` edges; DDR nibble order low-then-high is verified for byte 0xA5: rise carries 0x5, fall carries 0xA.

Source files
------------

// File: rtl/rgmii_xmit.sv
// rgmii_xmit: byte stream -> preamble/SFD framed GMII -> RGMII DDR pins.
// Optional RGMII_XMIT_FCS_EN: pad to 60 bytes and append CRC-32 FCS.
module rgmii_xmit #(
   parameter int IFG_BYTES      = 12,
   parameter int PREAMBLE_BYTES = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       busy,
   output logic       underrun,
   output logic       mii_txc,
   output logic [3:0] mii_txd,
   output logic       mii_txctl
);

   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
   localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_DRAIN,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       tx_en, tx_er, txc_q1;
   logic       en_n, er_n, unr_n;
   logic [7:0] txd, txd_n;
   logic [3:0] txd_q1, txd_q2;
   logic       ctl_q1, ctl_q2;

`ifdef RGMII_XMIT_FCS_EN
   logic [5:0]  bcnt, bcnt_n, bcnt_inc;
   logic [31:0] crc, crc_n, crc_inv;

   function automatic logic [31:0] crc_step(
      input logic [31:0] c_in,
      input logic [7:0]  b
   );
      logic [31:0] c;
      c = c_in ^ {24'h0, b};
      for (int k = 0; k < 8; k++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   assign bcnt_inc = (bcnt == 6'd60) ? 6'd60 : bcnt + 6'd1;
   assign crc_inv  = ~crc;
`endif

   assign busy = (state != S_IDLE);

   // Next-state, handshake and next GMII byte.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      en_n    = 1'b0;
      er_n    = 1'b0;
      txd_n   = 8'h00;
      unr_n   = 1'b0;
      s_ready = 1'b0;
`ifdef RGMII_XMIT_FCS_EN
      bcnt_n  = bcnt;
      crc_n   = crc;
`endif
      case (state)
         S_IDLE: begin
            if (s_valid) begin
               state_n = S_PREAMBLE;
               cnt_n   = '0;
            end
         end
         S_PREAMBLE: begin
            en_n  = 1'b1;
            txd_n = 8'h55;
            if (cnt == PRE_LAST)
               state_n = S_SFD;
            else
               cnt_n = cnt + 8'd1;
         end
         S_SFD: begin
            en_n    = 1'b1;
            txd_n   = 8'hD5;
            state_n = S_DATA;
`ifdef RGMII_XMIT_FCS_EN
            bcnt_n  = '0;
            crc_n   = '1;
`endif
         end
         S_DATA: begin
            s_ready = 1'b1;
            en_n    = 1'b1;
            if (s_valid) begin
               txd_n = s_data;
`ifdef RGMII_XMIT_FCS_EN
               bcnt_n = bcnt_inc;
               crc_n  = crc_step(crc, s_data);
`endif
               if (s_last) begin
                  cnt_n = '0;
`ifdef RGMII_XMIT_FCS_EN
                  if (bcnt_inc < 6'd60)
                     state_n = S_PAD;
                  else
                     state_n = S_FCS;
`else
                  state_n = S_IFG;
`endif
               end
            end else begin
               er_n    = 1'b1;
               unr_n   = 1'b1;
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            s_ready = 1'b1;
            if (s_valid && s_last) begin
               state_n = S_IFG;
               cnt_n   = '0;
            end
         end
`ifdef RGMII_XMIT_FCS_EN
         S_PAD: begin
            en_n   = 1'b1;
            bcnt_n = bcnt_inc;
            crc_n  = crc_step(crc, 8'h00);
            if (bcnt_inc == 6'd60) begin
               state_n = S_FCS;
               cnt_n   = '0;
            end
         end
         S_FCS: begin
            en_n  = 1'b1;
            txd_n = crc_inv[{cnt[1:0], 3'b000} +: 8];
            if (cnt[1:0] == 2'd3) begin
               state_n = S_IFG;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
`endif
         S_IFG: begin
            if (cnt == IFG_LAST) begin
               state_n = s_valid ? S_PREAMBLE : S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // FSM state and shared byte-time counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

`ifdef RGMII_XMIT_FCS_EN
   // Payload/pad byte count and running CRC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt <= '0;
         crc  <= '1;
      end else begin
         bcnt <= bcnt_n;
         crc  <= crc_n;
      end
   end
`endif

   // Registered GMII byte stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_en    <= 1'b0;
         tx_er    <= 1'b0;
         txd      <= 8'h00;
         underrun <= 1'b0;
      end else begin
         tx_en    <= en_n;
         tx_er    <= er_n;
         txd      <= txd_n;
         underrun <= unr_n;
      end
   end

   // oddr stage: capture both halves, d1 in high phase, d2 in low phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txc_q1 <= 1'b0;
         txd_q1 <= 4'h0;
         txd_q2 <= 4'h0;
         ctl_q1 <= 1'b0;
         ctl_q2 <= 1'b0;
      end else begin
         txc_q1 <= 1'b1;
         txd_q1 <= txd[3:0];
         txd_q2 <= txd[7:4];
         ctl_q1 <= tx_en;
         ctl_q2 <= tx_en ^ tx_er;
      end
   end

   assign mii_txc   = clk & txc_q1;
   assign mii_txd   = clk ? txd_q1 : txd_q2;
   assign mii_txctl = clk ? ctl_q1 : ctl_q2;

endmodule

// File: tb/tb_rgmii_xmit.sv
// tb_rgmii_xmit: random frames against a frame-level reference model.
// Decodes the DDR pins back to bytes and compares whole streams.
module tb_rgmii_xmit;

   localparam int IFG = 12;
   localparam int PRE = 7;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic       en;
      logic       er;
      logic [7:0] d;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready, busy, underrun;
   logic       mii_txc, mii_txctl;
   logic [3:0] mii_txd;

   int   errors = 0;
   int   checks = 0;
   int   unr_cnt = 0;
   int   txc_bad = 0;
   int   acc_cnt = 0;
   bit   abort = 1'b0;
   rec_t obs[$];

   rgmii_xmit #(
      .IFG_BYTES     (IFG),
      .PREAMBLE_BYTES(PRE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .busy     (busy),
      .underrun (underrun),
      .mii_txc  (mii_txc),
      .mii_txd  (mii_txd),
      .mii_txctl(mii_txctl)
   );

   always #4 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pin decoder: one record per byte-time, rise then fall half.
   always begin
      logic rc, rctl, rr, ur, fc, fctl;
      logic [3:0] rd, fd;
      rec_t r;
      @(posedge clk);
      #2;
      rc = mii_txc; rctl = mii_txctl; rd = mii_txd;
      ur = underrun; rr = rst;
      @(negedge clk);
      #2;
      fc = mii_txc; fctl = mii_txctl; fd = mii_txd;
      if (!rst && !rr) begin
         r.en = rctl;
         r.er = rctl ^ fctl;
         r.d  = {fd, rd};
         obs.push_back(r);
         if (ur) unr_cnt++;
         if (rc !== 1'b1 || fc !== 1'b0) txc_bad++;
      end
   end

`ifdef RGMII_XMIT_FCS_EN
   function automatic logic [31:0] crc_run(input logic [31:0] c0,
                                           input bq_t q);
      logic [31:0] c;
      c = c0;
      foreach (q[k]) begin
         c ^= {24'h0, q[k]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction
`endif

   function automatic int tail_len(input int n);
`ifdef RGMII_XMIT_FCS_EN
      return ((n < 60) ? 60 - n : 0) + 4;
`else
      return 0;
`endif
   endfunction

   // Expected wire bytes of one complete frame.
   task automatic build(input bq_t p, inout bq_t e);
      bq_t body;
      for (int k = 0; k < PRE; k++) e.push_back(8'h55);
      e.push_back(8'hD5);
      body = p;
`ifdef RGMII_XMIT_FCS_EN
      begin
         logic [31:0] fcs;
         while (body.size() < 60) body.push_back(8'h00);
         fcs = ~crc_run(32'hFFFFFFFF, body);
         for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
      end
`endif
      foreach (body[k]) e.push_back(body[k]);
   endtask

   task automatic send(input bq_t p, input int drop_at,
                       output int waits);
      int i = 0;
      int guard = 0;
      bit dropped = 1'b0;
      bit started = 1'b0;
      waits = 0;
      while (i < p.size() && !abort) begin
         @(negedge clk);
         if (abort) break;
         guard++;
         if (guard > 3000) begin
            check("send_timeout", 32'(i), 32'(p.size()));
            break;
         end
         if (s_ready) begin
            if (i == drop_at && !dropped) begin
               s_valid = 1'b0;
               dropped = 1'b1;
            end else begin
               s_valid = 1'b1;
               s_data  = p[i];
               s_last  = (i == p.size() - 1);
               i++;
               acc_cnt++;
               started = 1'b1;
            end
         end else begin
            s_valid = 1'b1;
            s_data  = 8'hEE;
            s_last  = 1'b0;
            if (!started) waits++;
         end
      end
   endtask

   task automatic go_idle(input int n);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic analyze(output bq_t bytes, output int er_idx[$],
                          output int gaps[$], output int trail);
      int  idle = 0;
      bit  seen = 1'b0;
      bytes.delete();
      er_idx.delete();
      gaps.delete();
      foreach (obs[k]) begin
         if (obs[k].en) begin
            if (seen && idle > 0) gaps.push_back(idle);
            idle = 0;
            seen = 1'b1;
            if (obs[k].er) er_idx.push_back(bytes.size());
            bytes.push_back(obs[k].d);
         end else begin
            idle++;
         end
      end
      trail = idle;
   endtask

   task automatic cmp_stream(input string tag, input bq_t got,
                             input bq_t exp);
      check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int k = 0; k < exp.size() && k < got.size(); k++)
         check($sformatf("%s_b%0d", tag, k), {24'h0, got[k]},
               {24'h0, exp[k]});
   endtask

   function automatic bq_t rand_payload(input int n);
      bq_t q;
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      return q;
   endfunction

   initial begin
      bq_t p, p2, e, got;
      int  er_idx[$];
      int  gaps[$];
      int  trail, w1, w2, n1, n2, u0;

      #6;
      check("rst_ready", {31'h0, s_ready}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_underrun", {31'h0, underrun}, 0);
      check("rst_txd_hi", {28'h0, mii_txd}, 0);
      check("rst_ctl_hi", {31'h0, mii_txctl}, 0);
      check("rst_txc_hi", {31'h0, mii_txc}, 0);
      #4;
      check("rst_txd_lo", {28'h0, mii_txd}, 0);
      check("rst_ctl_lo", {31'h0, mii_txctl}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 64-byte incrementing payload
      obs.delete();
      p.delete();
      for (int k = 0; k < 64; k++) p.push_back(8'(k));
      send(p, -1, w1);
      go_idle(90);
      analyze(got, er_idx, gaps, trail);
      e.delete();
      build(p, e);
      cmp_stream("t1", got, e);
`ifndef RGMII_XMIT_FCS_EN
      check("t1_en_cycles", 32'(got.size()), 72);
`endif
      check("t1_ifg_idle", {31'h0, trail >= IFG}, 1);
      check("t1_no_er", 32'(er_idx.size()), 0);
      check("t1_start_wait", 32'(w1), 32'(PRE + 2));

      // single byte 0xAB
      obs.delete();
      p.delete();
      p.push_back(8'hAB);
      send(p, -1, w1);
      go_idle(90);
      analyze(got, er_idx, gaps, trail);
      e.delete();
      build(p, e);
      cmp_stream("t2", got, e);
`ifdef RGMII_XMIT_FCS_EN
      check("t2_en_cycles", 32'(got.size()), 72);
      if (got.size() > PRE + 1) begin
         bq_t post;
         post = got[PRE + 1:$];
         check("t2_residue", crc_run(32'hFFFFFFFF, post), 32'hDEBB20E3);
      end
`endif

      // back-to-back random pairs
      for (int r = 0; r < 3; r++) begin
         n1 = $urandom_range(1, 80);
         n2 = $urandom_range(1, 80);
         p  = rand_payload(n1);
         p2 = rand_payload(n2);
         if (r == 0) p[0] = 8'hA5;
         obs.delete();
         send(p, -1, w1);
         send(p2, -1, w2);
         go_idle(100);
         analyze(got, er_idx, gaps, trail);
         e.delete();
         build(p, e);
         build(p2, e);
         cmp_stream($sformatf("t3_%0d", r), got, e);
         check("t3_runs", 32'(gaps.size()), 1);
         if (gaps.size() > 0) check("t3_gap", 32'(gaps[0]), IFG);
         check("t3_hold_wait", 32'(w2), 32'(tail_len(n1) + IFG + PRE + 1));
         if (r == 0 && got.size() > PRE + 1) begin
            check("ddr_rise", {28'h0, got[PRE + 1][3:0]}, 32'h5);
            check("ddr_fall", {28'h0, got[PRE + 1][7:4]}, 32'hA);
         end
      end

      // underrun after 10 payload bytes
      obs.delete();
      u0 = unr_cnt;
      p  = rand_payload(20);
      send(p, 10, w1);
      go_idle(100);
      analyze(got, er_idx, gaps, trail);
      e.delete();
      for (int k = 0; k < PRE; k++) e.push_back(8'h55);
      e.push_back(8'hD5);
      for (int k = 0; k < 10; k++) e.push_back(p[k]);
      e.push_back(8'h00);
      cmp_stream("t4", got, e);
      check("t4_er_count", 32'(er_idx.size()), 1);
      if (er_idx.size() > 0) check("t4_er_pos", 32'(er_idx[0]), 32'(e.size() - 1));
      check("t4_pulse", 32'(unr_cnt - u0), 1);
      check("t4_no_tail", 32'(gaps.size()), 0);

      // reset during the 5th payload byte
      acc_cnt = 0;
      abort   = 1'b0;
      p = rand_payload(20);
      fork
         send(p, -1, w1);
         begin
            int g;
            g = 0;
            while (acc_cnt < 5 && g < 500) begin
               @(negedge clk);
               #1;
               g++;
            end
            check("t5_reach", {31'h0, acc_cnt >= 5}, 1);
            @(posedge clk);
            #1;
            rst   = 1'b1;
            abort = 1'b1;
            #1;
            check("t5_busy", {31'h0, busy}, 0);
            check("t5_ready", {31'h0, s_ready}, 0);
            repeat (2) @(negedge clk);
            #1;
            check("t5_ctl_lo", {31'h0, mii_txctl}, 0);
            @(posedge clk);
            #1;
            check("t5_ctl_hi", {31'h0, mii_txctl}, 0);
         end
      join
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(negedge clk);
      rst   = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      obs.delete();
      p = rand_payload(8);
      send(p, -1, w1);
      go_idle(90);
      analyze(got, er_idx, gaps, trail);
      e.delete();
      build(p, e);
      cmp_stream("t5_next", got, e);
      check("t5_next_runs", 32'(gaps.size()), 0);

      check("txc_toggle", 32'(txc_bad), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
